bcd_digit_feeder: RTL and testbench

- Upstream stage of the 4-digit seven-segment scanner.
- Converts a 14-bit binary value (0..9999 nominal) to four BCD digits using sequential double-dabble (shift-add-3), one bit per cycle.
- Holds the digits stable between conversions.
- Generates the periodic one-cycle scan-enable strobe that paces the scanner.

---
 rtl/bcd_digit_feeder.sv | 77 +++++++
 tb/tb_bcd_digit_feeder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bcd_digit_feeder.sv
// bcd_digit_feeder: sequential double-dabble binary-to-BCD converter plus scan-enable divider
// Ports: clk, rst (sync active-high); start/bin_in request a conversion; busy while converting;
// done pulses when kilo/hundred/ten/single_digit and ovf are published; scan_en strobes every SCAN_DIV clks.
// Build option BCD_FEEDER_SAT_EN: values >= 10000 publish 9999 instead of value mod 10000.
module bcd_digit_feeder #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  single_digit,
  output logic [3:0]  ten_digit,
  output logic [3:0]  hundred_digit,
  output logic [3:0]  kilo_digit,
  output logic        scan_en
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_t;
  state_t state, state_nx;
  logic [13:0] sh;
  logic [19:0] acc;
  logic [18:0] adj;
  logic [15:0] pub;
  logic [3:0] it;
  logic [CW-1:0] cnt;
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign adj[4*g+:4] = acc[4*g+:4] >= 4'd5 ? acc[4*g+:4] + 4'd3 : acc[4*g+:4];
  end
  // a 14-bit input never drives the ten-thousands nibble past 1, so it needs no add-3
  assign adj[18:16] = acc[18:16];
`ifdef BCD_FEEDER_SAT_EN
  assign pub = |acc[19:16] ? 16'h9999 : acc[15:0];
`else
  assign pub = acc[15:0];
`endif
  assign busy = state != IDLE;
  assign scan_en = cnt == LAST;
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (it == 4'd13 ? PUBLISH : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      acc <= '0;
      it <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      {kilo_digit, hundred_digit, ten_digit, single_digit} <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      done <= state == PUBLISH;
      cnt <= scan_en ? '0 : cnt + 1'b1;
      if (state == IDLE && start) begin
        sh <= bin_in;
        acc <= '0;
        it <= '0;
      end
      if (state == SHIFT) begin
        acc <= {adj, sh[13]};
        sh <= {sh[12:0], 1'b0};
        it <= it + 4'd1;
      end
      if (state == PUBLISH) begin
        {kilo_digit, hundred_digit, ten_digit, single_digit} <= pub;
        ovf <= |acc[19:16];
      end
    end
  end
endmodule

// File: tb/tb_bcd_digit_feeder.sv
// tb_bcd_digit_feeder: scoreboard bench for bcd_digit_feeder
module tb_bcd_digit_feeder;
  logic clk = 0, rst = 1, start = 0;
  logic [13:0] bin_in = '0;
  logic busy, done, ovf, scan_en;
  logic [3:0] single_digit, ten_digit, hundred_digit, kilo_digit;
  logic [15:0] digs;
  bcd_digit_feeder #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy), .done(done), .ovf(ovf),
    .single_digit(single_digit), .ten_digit(ten_digit), .hundred_digit(hundred_digit),
    .kilo_digit(kilo_digit), .scan_en(scan_en)
  );
  assign digs = {kilo_digit, hundred_digit, ten_digit, single_digit};
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [16:0] v;
    int due;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  function automatic logic [16:0] model(int v);
    int d = v;
`ifdef BCD_FEEDER_SAT_EN
    if (v > 9999) d = 9999;
`endif
    return {4'(d / 1000 % 10), 4'(d / 100 % 10), 4'(d / 10 % 10), 4'(d % 10), v > 9999};
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got digits %0h want no done", digs);
      end else begin
        e = q.pop_front();
        check("result_digits_ovf", {15'd0, digs, ovf}, {15'd0, e.v});
        check("latency_cycle", cyc, e.due);
      end
    end
  end
  task automatic go(int v);
    exp_t e;
    start = 1;
    bin_in = 14'(v);
    e.v = model(v);
    e.due = cyc + 16;
    q.push_back(e);
    @(negedge clk);
    start = 0;
    check("busy_after_start", busy, 1);
  endtask
  task automatic wait_done;
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done want done");
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_digits", digs, 0);
    check("rst_scan_en", scan_en, 0);
    rst = 0;
    for (int j = 1; j <= 12; j++) begin
      check("scan_en_pattern", scan_en, (j % 4) == 0);
      @(negedge clk);
    end
    go(1234); wait_done;
    go(0); wait_done;
    go(9999); wait_done;
    go(12345); wait_done;
    @(negedge clk);
    check("ovf_held", ovf, 1);
    go(1234);
    repeat (4) @(negedge clk);
    start = 1;
    bin_in = 14'd5678;
    @(negedge clk);
    start = 0;
    check("busy_ignore_start", busy, 1);
    wait_done;
    go(5678);
    for (int j = 0; j < 13; j++) begin
      check("digits_hold", digs, 16'h1234);
      @(negedge clk);
    end
    wait_done;
    go(4321); wait_done;
    go(9876);
    repeat (6) @(negedge clk);
    rst = 1;
    start = 1;
    bin_in = 14'd77;
    q.delete();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_digits", digs, 0);
    check("abort_done", done, 0);
    check("abort_ovf", ovf, 0);
    rst = 0;
    start = 0;
    repeat (20) @(negedge clk);
    check("abort_digits_later", digs, 0);
    go(42); wait_done;
    for (int j = 0; j < 20; j++) begin
      go(int'($urandom_range(0, 16383)));
      wait_done;
    end
    repeat (20) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
